onehot_decoder_pipe: RTL
========================

// Module: onehot_decoder_pipe
// PURPOSE
//  Parametrised, registered binary-to-one-hot decoder with valid/ready handshakes on both sides.
//  Two modes:
//   - Direct decode: one index in, one one-hot beat out.
//   - Sweep: one index in, then NUM_OUT one-hot beats walking upward with wrap-around.
//  Drives strobe/select fan-out such as LED scanning, row select and channel enables.
// PARAMETERS
//  IN_W     3           width of binary index
//  NUM_OUT  1<<IN_W     number of one-hot outputs; 2 <= NUM_OUT <= 2**IN_W
//  DWELL    0           idle cycles inserted between sweep beats (out_valid low); 0..255
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        index request valid
//  in_ready     out  1        request accepted when in_valid & in_ready
//  in_idx       in   IN_W     binary index / sweep start index
//  in_sweep     in   1        0 = direct decode, 1 = sweep
//  flush        in   1        synchronous abort of any pending beat or sweep
//  out_valid    out  1        one-hot beat valid
//  out_ready    in   1        downstream accepts beat
//  out_onehot   out  NUM_OUT  one-hot select (all-zero for out-of-range in direct mode)
//  out_idx      out  IN_W     binary index of current beat
//  out_last     out  1        final beat of a request (always 1 in direct mode)
//  err          out  1        sticky out-of-range flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, except in_ready = 1 once rst_n is high; FSM = IDLE; counters 0.
//  Interface rules:
//   - Reset asserted mid-sweep aborts immediately; no residual beats after release.
//   - Output beat holds out_onehot/out_idx/out_last stable while out_valid & !out_ready.
//  FSM states: IDLE, OUT, SWEEP, GAP.
//  IDLE:
//   - in_ready = 1.
//   - Accept with in_sweep = 0 -> OUT.
//   - Accept with in_sweep = 1 -> SWEEP, start = (in_idx < NUM_OUT) ? in_idx : 0.
//  OUT (direct):
//   - out_valid = 1, out_last = 1; latency is 1 cycle from accept to out_valid.
//   - in_ready = out_ready, so back-to-back direct requests stream at 1 beat/clk.
//   - On out handshake: if a new request is accepted the same cycle, reload; else -> IDLE.
//  SWEEP:
//   - out_valid = 1, in_ready = 0.
//   - On out handshake, step = step + 1; idx = (idx == NUM_OUT-1) ? 0 : idx + 1.
//   - out_last = 1 when step == NUM_OUT-1; handshake of that beat -> IDLE.
//   - If DWELL > 0, every non-last handshake -> GAP.
//  GAP:
//   - out_valid = 0; count DWELL cycles, then -> SWEEP.
//  Width rules: step counter is clog2(NUM_OUT + 1) bits; the dwell counter is 8 bits.
//  Out of range in direct mode (in_idx >= NUM_OUT):
//   - A beat is still produced with out_onehot = 0 and out_idx = in_idx.
//  flush:
//   - Forces IDLE next cycle and deasserts out_valid.
//   - An in_valid presented in the same cycle is not accepted (in_ready = 0 while flush = 1).
//   - flush has priority over all handshakes.
// CONFIGURATION
//  Macro ONEHOT_DEC_RANGE_CHECK_EN:
//   - Defined: err is set when an out-of-range in_idx is accepted in either mode. err is sticky until
//     reset or flush. In sweep mode the request is still served starting at 0.
//   - Undefined: err is tied to 0 and no range-check logic is built. Data-path behaviour is identical.
// STRUCTURE
//  Package onehot_dec_pkg:
//   - state enum (IDLE/OUT/SWEEP/GAP) as localparams.
//   - a clog2 function and an idx-to-onehot function.
//  Sub-module onehot_dec_core: combinational IN_W -> NUM_OUT one-hot plus in_range flag; used for
//   both modes.
//  Top level holds the FSM, output registers, step/dwell counters and err.
// TESTING
//  1. IN_W=3, direct, out_ready=1, in_idx 0..7 back-to-back -> out_onehot 0x01..0x80 one clk after
//     each accept, 1 beat/clk, out_last=1 every beat.
//  2. Direct idx=5, out_ready low 3 clks -> out_onehot=0x20 held stable; in_ready=0 until handshake.
//  3. Sweep start 6, DWELL=0, out_ready=1 -> 8 beats idx 6,7,0..5; out_last only on idx 5; in_ready
//     returns to 1 next clk.
//  4. Sweep with DWELL=2 -> out_valid pattern 1,0,0,1,0,0...; total 8 beats; sweep spans 22 clks.
//  5. NUM_OUT=5, IN_W=3, direct idx=6 -> out_onehot=0, out_idx=6; err=1 with
//     ONEHOT_DEC_RANGE_CHECK_EN and 0 without; flush clears err.
//  6. rst_n low during beat 3 of sweep -> all outputs 0 asynchronously; after release, in_ready=1 and
//     no further beats.

Source files
------------

// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the one-hot decoder pipeline.
// Supports index widths up to 8 bits (MAX_OUT one-hot lanes).
package onehot_dec_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OUT,
      SWEEP,
      GAP
   } dec_state_t;

   localparam int unsigned MAX_OUT = 256;
   localparam int unsigned DWELL_W = 8;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Indices at or above n produce an all-zero vector.
   function automatic logic [MAX_OUT-1:0] idx2onehot(input int unsigned idx, input int unsigned n);
      logic [MAX_OUT-1:0] res;
      res = '0;
      if (idx < n) res[idx[7:0]] = 1'b1;
      return res;
   endfunction

endpackage

// File: rtl/onehot_dec_core.sv
// Combinational IN_W -> NUM_OUT one-hot decode with an in-range flag.
module onehot_dec_core
   import onehot_dec_pkg::*;
#(
   parameter int unsigned IN_W    = 3,
   parameter int unsigned NUM_OUT = 1 << IN_W
) (
   input  logic [IN_W-1:0]    idx,
   output logic [NUM_OUT-1:0] onehot,
   output logic               in_range
);

   always_comb begin
      onehot   = NUM_OUT'(idx2onehot(32'(idx), NUM_OUT));
      in_range = (32'(idx) < NUM_OUT);
   end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder with direct and sweep modes, valid/ready on both sides.
// Optional macro ONEHOT_DEC_RANGE_CHECK_EN builds the sticky out-of-range err flag.
module onehot_decoder_pipe
   import onehot_dec_pkg::*;
#(
   parameter int unsigned IN_W    = 3,
   parameter int unsigned NUM_OUT = 1 << IN_W,
   parameter int unsigned DWELL   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [IN_W-1:0]    in_idx,
   input  logic               in_sweep,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_OUT-1:0] out_onehot,
   output logic [IN_W-1:0]    out_idx,
   output logic               out_last,
   output logic               err
);

   localparam int unsigned STEP_W = clog2(NUM_OUT + 1);

   dec_state_t          state_q, state_d;
   logic [NUM_OUT-1:0]  onehot_q, onehot_d;
   logic [IN_W-1:0]     idx_q, idx_d, idx_inc, core_idx;
   logic                last_q, last_d;
   logic [STEP_W-1:0]   step_q, step_d, step_inc;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic [NUM_OUT-1:0]  dec_onehot, first_onehot;
   logic                dec_in_range;
   logic                acc, hs;

   // One decoder serves both the incoming index and the next sweep position.
   onehot_dec_core #(
      .IN_W    (IN_W),
      .NUM_OUT (NUM_OUT)
   ) u_core (
      .idx      (core_idx),
      .onehot   (dec_onehot),
      .in_range (dec_in_range)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         onehot_q <= '0;
         idx_q    <= '0;
         last_q   <= 1'b0;
         step_q   <= '0;
         dwell_q  <= '0;
      end else begin
         state_q  <= state_d;
         onehot_q <= onehot_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         step_q   <= step_d;
         dwell_q  <= dwell_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      onehot_d     = onehot_q;
      idx_d        = idx_q;
      last_d       = last_q;
      step_d       = step_q;
      dwell_d      = dwell_q;
      first_onehot = '0;
      first_onehot[0] = 1'b1;

      idx_inc  = (idx_q == IN_W'(NUM_OUT - 1)) ? '0 : idx_q + 1'b1;
      step_inc = step_q + 1'b1;
      core_idx = (state_q == SWEEP) ? idx_inc : in_idx;

      out_valid = ((state_q == OUT) || (state_q == SWEEP)) && !flush;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         OUT:     in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
      in_ready = in_ready && !flush && rst_n;

      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;

      if (flush) begin
         state_d = IDLE;
         dwell_d = '0;
      end else begin
         case (state_q)
            IDLE, OUT: begin
               if (acc) begin
                  step_d  = '0;
                  dwell_d = '0;
                  if (in_sweep) begin
                     state_d  = SWEEP;
                     last_d   = 1'b0;
                     idx_d    = dec_in_range ? in_idx : '0;
                     onehot_d = dec_in_range ? dec_onehot : first_onehot;
                  end else begin
                     state_d  = OUT;
                     last_d   = 1'b1;
                     idx_d    = in_idx;
                     onehot_d = dec_onehot;
                  end
               end else if (state_q == OUT && hs) begin
                  state_d = IDLE;
               end
            end
            SWEEP: begin
               if (hs) begin
                  if (last_q) begin
                     state_d = IDLE;
                  end else begin
                     step_d   = step_inc;
                     idx_d    = idx_inc;
                     onehot_d = dec_onehot;
                     last_d   = (step_inc == STEP_W'(NUM_OUT - 1));
                     dwell_d  = '0;
                     if (DWELL > 0) state_d = GAP;
                  end
               end
            end
            GAP: begin
               if (dwell_q == DWELL_W'(DWELL - 1)) begin
                  state_d = SWEEP;
                  dwell_d = '0;
               end else begin
                  dwell_d = dwell_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign out_onehot = onehot_q;
   assign out_idx    = idx_q;
   assign out_last   = last_q;

`ifdef ONEHOT_DEC_RANGE_CHECK_EN
   logic err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    err_q <= 1'b0;
      else if (flush)                err_q <= 1'b0;
      else if (acc && !dec_in_range) err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
